// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo ALU issue path: ALU opcodes, dispatch FSM
// states and the reservation-station entry layout at the default widths.
package tomasulo_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_TAG_W  = 3;
  localparam int HW_W       = 6;

  typedef enum logic [4:0] {
    PLUS_OP  = 5'd0,
    MINUS_OP = 5'd1,
    AND_OP   = 5'd2,
    OR_OP    = 5'd3,
    XOR_OP   = 5'd4,
    SLL_OP   = 5'd5,
    SRL_OP   = 5'd6,
    SRA_OP   = 5'd7,
    SLT_OP   = 5'd8,
    SLTU_OP  = 5'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_ISSUE = 2'd1,
    DS_WAIT  = 2'd2
  } ds_state_t;

  typedef struct packed {
    logic                  valid;
    alu_op_t               op;
    logic [DEF_TAG_W-1:0]  tag;
    logic [HW_W-1:0]       hw;
    logic                  a_rdy;
    logic [DEF_DATA_W-1:0] a_val;
    logic [DEF_TAG_W-1:0]  a_tag;
    logic                  b_rdy;
    logic [DEF_DATA_W-1:0] b_val;
    logic [DEF_TAG_W-1:0]  b_tag;
  } rs_entry_t;

  function automatic logic tag_hit(input logic                 bus_vld,
                                   input logic [DEF_TAG_W-1:0] bus_tag,
                                   input logic [DEF_TAG_W-1:0] want_tag);
    return bus_vld && (bus_tag == want_tag);
  endfunction

endpackage

// File: rtl/rs_pick_lowest.sv
// Lowest-index priority encoder: index of the lowest set request bit plus
// an any-request flag.
module rs_pick_lowest #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers renamed ops, wakes operands from the CDB
// and hands one ready op at a time to the execute unit via start/done.
module alu_reservation_station
  import tomasulo_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int OCC_W  = $clog2(ENTRIES + 1),
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op_t           in_op,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_a_rdy,
  input  logic              in_b_rdy,
  input  logic [DATA_W-1:0] in_a_val,
  input  logic [DATA_W-1:0] in_b_val,
  input  logic [TAG_W-1:0]  in_a_tag,
  input  logic [TAG_W-1:0]  in_b_tag,
  input  logic [HW_W-1:0]   in_hw,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              ex_start,
  output alu_op_t           ex_op,
  output logic [DATA_W-1:0] ex_vala,
  output logic [DATA_W-1:0] ex_valb,
  output logic [HW_W-1:0]   ex_valhw,
  output logic [TAG_W-1:0]  ex_tag,
  input  logic              ex_done,
  output logic [OCC_W-1:0]  occupancy
);

  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(ENTRIES);

  rs_entry_t         ent_q [ENTRIES];
  rs_entry_t         ent_d [ENTRIES];
  rs_entry_t         new_ent;
  logic [ENTRIES-1:0] free_vec, rdy_vec;
  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic              free_any, sel_any;
  logic              ins, disp;
  ds_state_t         ds_q, ds_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  alu_op_t           ex_op_q;
  logic [DATA_W-1:0] ex_vala_q, ex_valb_q;
  logic [HW_W-1:0]   ex_valhw_q;
  logic [TAG_W-1:0]  ex_tag_q;

  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i] = ~ent_q[i].valid;
      rdy_vec[i]  = ent_q[i].valid & ent_q[i].a_rdy & ent_q[i].b_rdy;
    end
  end

  rs_pick_lowest #(.N(ENTRIES)) u_pick_free (
    .req_i (free_vec),
    .idx_o (free_idx),
    .any_o (free_any)
  );

  rs_pick_lowest #(.N(ENTRIES)) u_pick_rdy (
    .req_i (rdy_vec),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  assign in_ready  = (occ_q < FULL_CNT);
  assign ins       = in_valid & in_ready & free_any;
  assign disp      = (ds_q == DS_IDLE) & sel_any;
  assign occupancy = occ_q;

  // Incoming op, with same-cycle CDB bypass for operands still in flight
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.op    = in_op;
    new_ent.tag   = in_tag;
    new_ent.hw    = in_hw;
    new_ent.a_rdy = in_a_rdy;
    new_ent.a_val = in_a_val;
    new_ent.a_tag = in_a_tag;
    new_ent.b_rdy = in_b_rdy;
    new_ent.b_val = in_b_val;
    new_ent.b_tag = in_b_tag;
    if (!in_a_rdy && tag_hit(cdb_valid, cdb_tag, in_a_tag)) begin
      new_ent.a_rdy = 1'b1;
      new_ent.a_val = cdb_val;
    end
    if (!in_b_rdy && tag_hit(cdb_valid, cdb_tag, in_b_tag)) begin
      new_ent.b_rdy = 1'b1;
      new_ent.b_val = cdb_val;
    end
  end

  // Free selection uses registered valid bits, so an insert can never land
  // in the slot that dispatch is releasing this cycle.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        if (!ent_q[i].a_rdy && tag_hit(cdb_valid, cdb_tag, ent_q[i].a_tag)) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = cdb_val;
        end
        if (!ent_q[i].b_rdy && tag_hit(cdb_valid, cdb_tag, ent_q[i].b_tag)) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = cdb_val;
        end
      end
      if (disp && (sel_idx == IDX_W'(i))) ent_d[i].valid = 1'b0;
      if (ins && (free_idx == IDX_W'(i))) ent_d[i] = new_ent;
    end
  end

  always_comb begin
    ds_d = ds_q;
    case (ds_q)
      DS_IDLE:  if (sel_any) ds_d = DS_ISSUE;
      DS_ISSUE: ds_d = DS_WAIT;
      DS_WAIT:  if (ex_done) ds_d = DS_IDLE;
      default:  ds_d = DS_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q + OCC_W'(ins) - OCC_W'(disp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_q       <= DS_IDLE;
      occ_q      <= '0;
      ex_op_q    <= PLUS_OP;
      ex_vala_q  <= '0;
      ex_valb_q  <= '0;
      ex_valhw_q <= '0;
      ex_tag_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_q[i].valid <= 1'b0;
    end else begin
      ds_q  <= ds_d;
      occ_q <= occ_d;
      if (disp) begin
        ex_op_q    <= ent_q[sel_idx].op;
        ex_vala_q  <= ent_q[sel_idx].a_val;
        ex_valb_q  <= ent_q[sel_idx].b_val;
        ex_valhw_q <= ent_q[sel_idx].hw;
        ex_tag_q   <= ent_q[sel_idx].tag;
      end
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign ex_start = (ds_q == DS_ISSUE);
  assign ex_op    = ex_op_q;
  assign ex_vala  = ex_vala_q;
  assign ex_valb  = ex_valb_q;
  assign ex_valhw = ex_valhw_q;
  assign ex_tag   = ex_tag_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: issue latency, CDB wakeup and
// bypass, full/ordering behaviour, start/done handshake and reset mid-op.
module tb_alu_reservation_station;
  import tomasulo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_a_rdy, in_b_rdy;
  alu_op_t     in_op, ex_op;
  logic [2:0]  in_tag, in_a_tag, in_b_tag, cdb_tag, ex_tag, occupancy;
  logic [63:0] in_a_val, in_b_val, cdb_val, ex_vala, ex_valb;
  logic [5:0]  in_hw, ex_valhw;
  logic        cdb_valid, ex_start, ex_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.ENTRIES(4), .TAG_W(3), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .in_a_rdy(in_a_rdy), .in_b_rdy(in_b_rdy),
    .in_a_val(in_a_val), .in_b_val(in_b_val),
    .in_a_tag(in_a_tag), .in_b_tag(in_b_tag), .in_hw(in_hw),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .ex_start(ex_start), .ex_op(ex_op), .ex_vala(ex_vala), .ex_valb(ex_valb),
    .ex_valhw(ex_valhw), .ex_tag(ex_tag), .ex_done(ex_done),
    .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input alu_op_t op, input logic [2:0] tag,
                         input logic ar, input logic [63:0] av, input logic [2:0] at,
                         input logic br, input logic [63:0] bv, input logic [2:0] bt,
                         input logic [5:0] hw);
    in_valid = 1'b1; in_op = op; in_tag = tag; in_hw = hw;
    in_a_rdy = ar; in_a_val = av; in_a_tag = at;
    in_b_rdy = br; in_b_val = bv; in_b_tag = bt;
  endtask

  task automatic ins(input alu_op_t op, input logic [2:0] tag,
                     input logic ar, input logic [63:0] av, input logic [2:0] at,
                     input logic br, input logic [63:0] bv, input logic [2:0] bt,
                     input logic [5:0] hw);
    set_ins(op, tag, ar, av, at, br, bv, bt, hw);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic bcast(input logic [2:0] tag, input logic [63:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic pulse_done();
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = PLUS_OP; in_tag = '0; in_hw = '0;
    in_a_rdy = 1'b0; in_b_rdy = 1'b0; in_a_val = '0; in_b_val = '0;
    in_a_tag = '0; in_b_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
    ex_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_start", ex_start, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_tag", ex_tag, 0);
    chk("rst_vala", ex_vala, 0);

    // ready insert: start two cycles after insert
    ins(PLUS_OP, 3'd2, 1'b1, 64'd5, 3'd0, 1'b1, 64'd7, 3'd0, 6'd3);
    chk("t1_nostart", ex_start, 0);
    chk("t1_occ1", occupancy, 1);
    tick();
    chk("t1_start", ex_start, 1);
    chk("t1_vala", ex_vala, 5);
    chk("t1_valb", ex_valb, 7);
    chk("t1_tag", ex_tag, 2);
    chk("t1_hw", ex_valhw, 3);
    chk("t1_op", ex_op, PLUS_OP);
    chk("t1_occ0", occupancy, 0);

    // handshake: second ready op waits while ex_done stays low
    ins(MINUS_OP, 3'd5, 1'b1, 64'd1, 3'd0, 1'b1, 64'd2, 3'd0, 6'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hs_nostart", ex_start, 0);
      chk("hs_vala_hold", ex_vala, 5);
      chk("hs_tag_hold", ex_tag, 2);
      tick();
    end
    chk("hs_occ", occupancy, 1);
    pulse_done();
    chk("hs_d1", ex_start, 0);
    tick();
    chk("hs_d2_start", ex_start, 1);
    chk("hs_d2_vala", ex_vala, 1);
    chk("hs_d2_tag", ex_tag, 5);
    tick();
    pulse_done();

    // CDB wakeup, wrong tag first
    ins(AND_OP, 3'd1, 1'b0, 64'd0, 3'd4, 1'b1, 64'd1, 3'd0, 6'd0);
    bcast(3'd5, 64'hff);
    chk("wk_wrongtag", ex_start, 0);
    tick();
    chk("wk_wait", ex_start, 0);
    bcast(3'd4, 64'h10);
    chk("wk_c1", ex_start, 0);
    tick();
    chk("wk_start", ex_start, 1);
    chk("wk_vala", ex_vala, 64'h10);
    chk("wk_valb", ex_valb, 1);
    chk("wk_tag", ex_tag, 1);
    tick();
    pulse_done();

    // insert bypass
    set_ins(OR_OP, 3'd6, 1'b0, 64'd0, 3'd3, 1'b1, 64'd2, 3'd0, 6'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_val = 64'd9;
    tick();
    in_valid = 1'b0; cdb_valid = 1'b0;
    chk("bp_nostart", ex_start, 0);
    tick();
    chk("bp_start", ex_start, 1);
    chk("bp_vala", ex_vala, 9);
    chk("bp_tag", ex_tag, 6);
    tick();
    pulse_done();

    // full and ordering
    for (int i = 0; i < 4; i++)
      ins(XOR_OP, 3'(i), 1'b0, 64'd0, 3'(i + 1), 1'b1, 64'(100 + i), 3'd0, 6'd0);
    chk("full_occ", occupancy, 4);
    chk("full_ready", in_ready, 0);
    ins(PLUS_OP, 3'd7, 1'b1, 64'd1, 3'd0, 1'b1, 64'd1, 3'd0, 6'd0);
    chk("full_drop_occ", occupancy, 4);
    tick();
    chk("full_drop_nostart", ex_start, 0);
    bcast(3'd1, 64'h20);
    tick();
    chk("ord_e0_start", ex_start, 1);
    chk("ord_e0_tag", ex_tag, 0);
    chk("ord_e0_vala", ex_vala, 64'h20);
    chk("ord_e0_valb", ex_valb, 100);
    chk("ord_occ3", occupancy, 3);
    chk("ord_ready", in_ready, 1);
    bcast(3'd4, 64'h44);
    bcast(3'd2, 64'h22);
    chk("ord_wait", ex_start, 0);
    pulse_done();
    chk("ord_d1", ex_start, 0);
    tick();
    chk("ord_e1_start", ex_start, 1);
    chk("ord_e1_tag", ex_tag, 1);
    chk("ord_e1_vala", ex_vala, 64'h22);
    chk("ord_e1_valb", ex_valb, 101);
    tick();
    pulse_done();
    tick();
    chk("ord_e3_start", ex_start, 1);
    chk("ord_e3_tag", ex_tag, 3);
    chk("ord_e3_vala", ex_vala, 64'h44);
    chk("ord_e3_valb", ex_valb, 103);
    tick();
    pulse_done();
    chk("ord_occ1", occupancy, 1);

    // ex_done ignored in IDLE and ISSUE
    pulse_done();
    chk("idle_done_start", ex_start, 0);
    chk("idle_done_occ", occupancy, 1);
    ins(SLL_OP, 3'd6, 1'b1, 64'd8, 3'd0, 1'b1, 64'd9, 3'd0, 6'd17);
    ins(SRL_OP, 3'd7, 1'b1, 64'd3, 3'd0, 1'b1, 64'd4, 3'd0, 6'd0);
    chk("iss_start", ex_start, 1);
    chk("iss_tag", ex_tag, 6);
    chk("iss_hw", ex_valhw, 17);
    chk("iss_op", ex_op, SLL_OP);
    pulse_done();
    for (int i = 0; i < 3; i++) begin
      chk("iss_done_ignored", ex_start, 0);
      chk("iss_tag_hold", ex_tag, 6);
      tick();
    end
    pulse_done();
    tick();
    chk("iss_b_start", ex_start, 1);
    chk("iss_b_tag", ex_tag, 7);
    tick();

    // reset in DS_WAIT with two entries valid
    ins(PLUS_OP, 3'd5, 1'b0, 64'd0, 3'd5, 1'b1, 64'd0, 3'd0, 6'd0);
    chk("mr_occ2", occupancy, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_occ0", occupancy, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_start", ex_start, 0);
    chk("mr_tag", ex_tag, 0);
    chk("mr_vala", ex_vala, 0);
    pulse_done();
    bcast(3'd3, 64'd1);
    bcast(3'd5, 64'd2);
    tick();
    chk("mr_nostart1", ex_start, 0);
    tick();
    chk("mr_nostart2", ex_start, 0);
    chk("mr_occ_after", occupancy, 0);
    ins(PLUS_OP, 3'd4, 1'b1, 64'd11, 3'd0, 1'b1, 64'd22, 3'd0, 6'd0);
    tick();
    chk("mr_new_start", ex_start, 1);
    chk("mr_new_vala", ex_vala, 11);
    chk("mr_new_tag", ex_tag, 4);
    tick();
    pulse_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Issue-side counterpart of the arithmetic execute unit in the Tomasulo core: buffers decoded ALU operations, captures missing operands from the common data bus (CDB), and drives the execute unit's start/done handshake one operation at a time. It sits between the decode/rename stage and the execute unit. Each operation leaves with its destination tag so the result can be broadcast on the CDB.

## Interface
- ENTRIES, 4, number of station slots (≥2)
- TAG_W, 3, width of producer/destination tags
- DATA_W, 64, operand width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  insert request from decode
- in_ready  out  1  station not full; insert accepted when in_valid & in_ready
- in_op  in  5  alu_op_t
- in_tag  in  TAG_W  destination tag
- in_a_rdy / in_b_rdy  in  1  operand already available
- in_a_val / in_b_val  in  DATA_W  operand value, meaningful when rdy
- in_a_tag / in_b_tag  in  TAG_W  producer tag, meaningful when not rdy
- in_hw  in  6  shift amount (valhw)
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_val  in  DATA_W  broadcast value
- ex_start  out  1  one-cycle start pulse to the execute unit
- ex_op  out  5  operation
- ex_vala / ex_valb  out  DATA_W  operands
- ex_valhw  out  6  shift amount
- ex_tag  out  TAG_W  destination tag of the issued operation
- ex_done  in  1  execute-unit completion pulse
- occupancy  out  $clog2(ENTRIES+1)  valid entry count

## Operation
- Entry fields: valid, op, tag, hw, a_rdy/a_val/a_tag, b_rdy/b_val/b_tag.
- Insert: written into the lowest-index free entry.
- CDB capture: every cycle, each valid entry with a non-ready operand whose tag equals cdb_tag (cdb_valid=1) latches cdb_val and sets rdy. Both operands of one entry can capture in the same cycle.
- Insert bypass: if an inserted operand is not ready and cdb matches its tag in the insert cycle, it is stored ready with cdb_val.
- Entry ready = valid & a_rdy & b_rdy, evaluated on registered state.
- Dispatch FSM (ds_state_t):
  - DS_IDLE: if any entry is ready, pick the lowest-index one, register ex_* from it, free it, go to DS_ISSUE; otherwise stay.
  - DS_ISSUE: ex_start=1 for this cycle only. Go to DS_WAIT.
  - DS_WAIT: on ex_done, go to DS_IDLE. Otherwise stay.
- ex_done is ignored in DS_IDLE and DS_ISSUE. The execute unit never asserts it before the cycle after start.
- At most one operation is outstanding.
- in_ready = (occupancy < ENTRIES), from registered occupancy. A slot freed by dispatch becomes insertable the next cycle.
- occupancy: +1 on insert, −1 on dispatch. Both in one cycle leaves it unchanged.

## Timing
- Reset: all entries invalid, FSM DS_IDLE, ex_start=0, ex_op/ex_vala/ex_valb/ex_valhw/ex_tag=0, occupancy=0, in_ready=1.
- Reset mid-operation discards all entries and any outstanding operation. A later ex_done is ignored.
- Latency: insert with both operands ready in cycle t → ex_start high in cycle t+2.
- Operand arriving on CDB in cycle t (entry already present) → eligible for select in t+1, ex_start in t+2.
- ex_* hold stable from DS_ISSUE through the ex_done cycle.
- Back-to-back: ex_done in cycle d → next ex_start no earlier than d+2.
- Full: in_valid ignored while in_ready=0, with no state change.
- Insert and dispatch in the same cycle are both honoured. The insert never targets the slot being freed that cycle.

## Structure
- tomasulo_pkg: alu_op_t, ds_state_t {DS_IDLE, DS_ISSUE, DS_WAIT}, rs_entry_t packed struct, and the DATA_W/TAG_W defaults.
- Sub-module rs_pick_lowest: parameterised lowest-index one-hot/index priority encoder. It is used twice: free-slot selection and ready selection.

## Test plan
- Ready insert: insert PLUS_OP, a=5, b=7, tag=2 at t → ex_start at t+2 with vala=5, valb=7, ex_tag=2; occupancy returns to 0.
- CDB wakeup: insert with a waiting on tag 4, b=1; cdb(tag 4, val 0x10) three cycles later → issue with vala=0x10 two cycles after the broadcast.
- Insert bypass: insert a waiting on tag 3 while cdb(tag 3, 9) is in the same cycle → issued with vala=9, no further CDB needed.
- Full/ordering: fill 4 entries (none ready) → in_ready=0 and a 5th insert is dropped. Wake entries 3 then 1 → entry 1 issues first if both are ready when the FSM is in DS_IDLE.
- Handshake: hold ex_done low 5 cycles → no second ex_start and ex_* stable. ex_done pulsed in DS_IDLE → no effect.
- Reset mid-WAIT: rst in DS_WAIT with 2 entries valid → occupancy=0, ex_start=0, and a following ex_done is ignored.
